// File: rtl/div_share_arbiter_if.sv
// div_share_arbiter_if: client-side and divider-core-side signals of the
// shared divider scheduler, bundled into one interface.
//   slave  : the scheduler itself
//   master : its environment (the requesting clients plus the divider core)
//
// Handshakes (all single-clock, sampled on the rising edge):
//   req/gnt        : a client raises req[i] with operands on a_flat/b_flat and
//                    holds both until gnt[i] pulses for one cycle; in that
//                    cycle the operands are captured and req[i] may drop.
//   div_start/done : div_start pulses once with div_a/div_b valid; the
//                    operands stay stable until the core answers with a
//                    one-cycle div_done carrying div_q/div_r.
//   rsp_valid      : one-cycle, one-hot pulse; quotient/remainder/rsp_err
//                    are meaningful only in that cycle. There is no
//                    back-pressure: a client must accept it.
interface div_share_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] a_flat;
  logic [NREQ*WIDTH-1:0] b_flat;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]      quotient;
  logic [WIDTH-1:0]      remainder;
  logic                  rsp_err;
  logic                  busy;
  logic                  div_start;
  logic [WIDTH-1:0]      div_a;
  logic [WIDTH-1:0]      div_b;
  logic                  div_done;
  logic [WIDTH-1:0]      div_q;
  logic [WIDTH-1:0]      div_r;

  modport slave (
    input  req, a_flat, b_flat, div_done, div_q, div_r,
    output gnt, rsp_valid, quotient, remainder, rsp_err, busy,
           div_start, div_a, div_b
  );

  modport master (
    output req, a_flat, b_flat, div_done, div_q, div_r,
    input  gnt, rsp_valid, quotient, remainder, rsp_err, busy,
           div_start, div_a, div_b
  );
endinterface

// File: rtl/div_share_arbiter.sv
// div_share_arbiter: round-robin scheduler sharing one sequential divider
// core among NREQ requesters. One division is outstanding at a time; the
// result returns to the granted requester as a one-cycle rsp_valid pulse.
// Optional feature macro: DIV_ZERO_CHECK_EN -- when defined, a request with
// divisor 0 is answered locally (quotient all ones, remainder = dividend,
// rsp_err = 1) without starting the core. When undefined, b = 0 goes to the
// core like any other operand and rsp_err is tied low.
// Debug: dbg_state_o shows the FSM state (0 = IDLE, 1 = WAIT, 2 = RESP),
// dbg_ptr_o the round-robin search start.
module div_share_arbiter #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  div_share_arbiter_if.slave bus,
  output logic [1:0]         dbg_state_o,
  output logic [IDW-1:0]     dbg_ptr_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);
  localparam logic [IDW:0]    NREQ_W   = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0]  LAST_ID  = IDW'(NREQ-1);

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic             div_start_q, div_start_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic [WIDTH-1:0] div_a_q, div_a_d;
  logic [WIDTH-1:0] div_b_q, div_b_d;
`ifdef DIV_ZERO_CHECK_EN
  logic             rsp_err_q, rsp_err_d;
  logic             zero_q, zero_d;
`endif

  // Arbitration signals: requests rotated so that bit 0 is the slot at ptr.
  logic [NREQ-1:0]  req_rot;
  logic             sel_found;
  logic [IDW-1:0]   sel_off;
  logic [IDW:0]     sel_sum;
  logic [IDW-1:0]   sel_id;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  // Round-robin pick: first set request at or above ptr, wrapping at NREQ.
  always_comb begin
    req_rot   = NREQ'({bus.req, bus.req} >> ptr_q);
    sel_found = |req_rot;
    sel_off   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_rot[k]) sel_off = IDW'(k);
    end
    sel_sum = {1'b0, ptr_q} + {1'b0, sel_off};
    if (sel_sum >= NREQ_W) sel_sum = sel_sum - NREQ_W;
    sel_id = IDW'(sel_sum);
  end

  // Operand mux for the selected slot.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (sel_id == IDW'(k)) begin
        sel_a = bus.a_flat[k*WIDTH +: WIDTH];
        sel_b = bus.b_flat[k*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state and registered-output logic; pulses default low each cycle.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    gnt_d       = '0;
    rsp_valid_d = '0;
    div_start_d = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_a_d     = div_a_q;
    div_b_d     = div_b_q;
`ifdef DIV_ZERO_CHECK_EN
    rsp_err_d   = 1'b0;
    zero_d      = zero_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          id_d    = sel_id;
          div_a_d = sel_a;
          div_b_d = sel_b;
          gnt_d   = ONE_HOT0 << sel_id;
          state_d = S_WAIT;
`ifdef DIV_ZERO_CHECK_EN
          // A zero divisor never reaches the core; WAIT answers it next edge.
          zero_d      = (sel_b == '0);
          div_start_d = (sel_b != '0);
`else
          div_start_d = 1'b1;
`endif
        end
      end
      S_WAIT: begin
`ifdef DIV_ZERO_CHECK_EN
        if (zero_q) begin
          quotient_d  = '1;
          remainder_d = div_a_q;
          rsp_err_d   = 1'b1;
          rsp_valid_d = ONE_HOT0 << id_q;
          zero_d      = 1'b0;
          state_d     = S_RESP;
        end else if (bus.div_done) begin
          quotient_d  = bus.div_q;
          remainder_d = bus.div_r;
          rsp_valid_d = ONE_HOT0 << id_q;
          state_d     = S_RESP;
        end
`else
        if (bus.div_done) begin
          quotient_d  = bus.div_q;
          remainder_d = bus.div_r;
          rsp_valid_d = ONE_HOT0 << id_q;
          state_d     = S_RESP;
        end
`endif
      end
      S_RESP: begin
        // Next search starts just above the requester that was served.
        ptr_d   = (id_q == LAST_ID) ? '0 : id_q + 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      div_start_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_a_q     <= '0;
      div_b_q     <= '0;
`ifdef DIV_ZERO_CHECK_EN
      rsp_err_q   <= 1'b0;
      zero_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      div_start_q <= div_start_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_a_q     <= div_a_d;
      div_b_q     <= div_b_d;
`ifdef DIV_ZERO_CHECK_EN
      rsp_err_q   <= rsp_err_d;
      zero_q      <= zero_d;
`endif
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.div_start = div_start_q;
  assign bus.div_a     = div_a_q;
  assign bus.div_b     = div_b_q;
  assign bus.busy      = (state_q != S_IDLE);
`ifdef DIV_ZERO_CHECK_EN
  assign bus.rsp_err   = rsp_err_q;
`else
  assign bus.rsp_err   = 1'b0;
`endif

  assign dbg_state_o = state_q;
  assign dbg_ptr_o   = ptr_q;

endmodule

// File: tb/tb_div_share_arbiter.sv
// tb_div_share_arbiter: directed and randomized bench for div_share_arbiter.
// The bench plays both the clients and the divider core (random latency).
// Expected grants come from a round-robin model over the pending-request
// mask; expected results from plain unsigned / and %.
module tb_div_share_arbiter;
  localparam int WIDTH = 16;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  div_share_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();
  logic [1:0]     dbg_state;
  logic [IDW-1:0] dbg_ptr;

  div_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state),
    .dbg_ptr_o   (dbg_ptr)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- model state / scoreboard ----------------
  logic [NREQ-1:0]    req_m;
  logic [WIDTH-1:0]   a_m [NREQ];
  logic [WIDTH-1:0]   b_m [NREQ];
  int                 ptr_m;
  logic [2*WIDTH-1:0] exp_q [$];
  logic [2*WIDTH-1:0] last_res;
  int n_checks = 0;
  int n_errors = 0;
  int n_gnt_seen = 0, n_rsp_seen = 0;
  int n_gnt_exp = 0, n_rsp_exp = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Round-robin rule: first pending slot at or after p, wrapping.
  function automatic int pick(input logic [NREQ-1:0] m, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (m[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  // Unsigned division result {q, r}; a zero divisor yields all ones and a.
  function automatic logic [2*WIDTH-1:0] ref_div(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    if (b == '0) return {{WIDTH{1'b1}}, a};
    return {a / b, a % b};
  endfunction

  function automatic logic [WIDTH-1:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return WIDTH'(1);
      default: return WIDTH'($urandom);
    endcase
  endfunction

  // Pulse counters, compared against the model totals at the end.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.gnt != '0) n_gnt_seen++;
      if (bus.rsp_valid != '0) n_rsp_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_req();
    bus.req = req_m;
    for (int i = 0; i < NREQ; i++) begin
      bus.a_flat[i*WIDTH +: WIDTH] = a_m[i];
      bus.b_flat[i*WIDTH +: WIDTH] = b_m[i];
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_m = '0;
    drive_req();
    bus.div_done = 1'b0;
    repeat (3) @(negedge clk);
    rst_n    = 1'b1;
    ptr_m    = 0;
    last_res = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_gnt"},       bus.gnt, 0);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_div_start"}, bus.div_start, 0);
    chk({tag, "_busy"},      bus.busy, 0);
    chk({tag, "_rsp_err"},   bus.rsp_err, 0);
    chk({tag, "_quotient"},  bus.quotient, 0);
    chk({tag, "_remainder"}, bus.remainder, 0);
    chk({tag, "_div_a"},     bus.div_a, 0);
    chk({tag, "_div_b"},     bus.div_b, 0);
    chk({tag, "_ptr"},       dbg_ptr, 0);
    chk({tag, "_state"},     dbg_state, 0);
  endtask

  // Serve one request end to end. Called at a negedge with req_m already
  // driven and the DUT idle: the grant must appear one cycle later.
  task automatic do_txn(input bit hold);
    int id, waited, lat;
    bit zero_path;
    logic [2*WIDTH-1:0] e;
    id = pick(req_m, ptr_m);
    zero_path = 1'b0;
`ifdef DIV_ZERO_CHECK_EN
    zero_path = (b_m[id] == '0);
`endif
    exp_q.push_back(ref_div(a_m[id], b_m[id]));
    n_gnt_exp++;
    n_rsp_exp++;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (bus.gnt == '0 && waited < 40);
    chk("gnt_latency", waited, 1);
    chk("gnt_onehot", bus.gnt, 32'd1 << id);
    chk("div_start", bus.div_start, {31'd0, !zero_path});
    chk("div_a", bus.div_a, a_m[id]);
    chk("div_b", bus.div_b, b_m[id]);
    chk("busy_rise", bus.busy, 1);
    if (!hold) begin
      req_m[id] = 1'b0;
      drive_req();
    end
    if (!zero_path) begin
      lat = $urandom_range(1, 5);
      for (int c = 0; c < lat; c++) begin
        @(negedge clk);
        if (c == 0) chk("start_pulse_drop", bus.div_start, 0);
        if (c == lat - 1) chk("no_early_rsp", bus.rsp_valid, 0);
      end
      // Divider core answers from the operands it was handed.
      bus.div_done = 1'b1;
      {bus.div_q, bus.div_r} = ref_div(bus.div_a, bus.div_b);
      @(negedge clk);
      bus.div_done = 1'b0;
      bus.div_q    = '0;
      bus.div_r    = '0;
    end else begin
      @(negedge clk);
    end
    e = exp_q.pop_front();
    last_res = e;
    chk("rsp_valid", bus.rsp_valid, 32'd1 << id);
    chk("quotient", bus.quotient, e[2*WIDTH-1:WIDTH]);
    chk("remainder", bus.remainder, e[WIDTH-1:0]);
    chk("rsp_err", bus.rsp_err, {31'd0, zero_path});
    ptr_m = (id + 1) % NREQ;
    @(negedge clk);
    chk("rsp_drop", bus.rsp_valid, 0);
    chk("busy_fall", bus.busy, 0);
    chk("ptr", dbg_ptr, ptr_m);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit seen;
    bus.req = '0; bus.a_flat = '0; bus.b_flat = '0;
    bus.div_done = 1'b0; bus.div_q = '0; bus.div_r = '0;
    for (int i = 0; i < NREQ; i++) begin a_m[i] = '0; b_m[i] = '0; end

    do_reset();
    check_reset_outputs("por");

    // Single request on slot 0: 32200 / 37 = 870 rem 10.
    a_m[0] = 16'd32200; b_m[0] = 16'd37; req_m = 4'b0001; drive_req();
    do_txn(1'b0);
    chk("single_q_const", bus.quotient, 870);

    // Round robin with all requests held from a fresh pointer: 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < NREQ; i++) begin a_m[i] = 16'd1000; b_m[i] = 16'd7; end
    req_m = 4'b1111; drive_req();
    for (int n = 0; n < 5; n++) do_txn(1'b1);
    req_m = '0; drive_req();

    // Priority wrap: serve slot 2, then 0101 must go 0 then 2.
    a_m[2] = 16'd999; b_m[2] = 16'd10; req_m = 4'b0100; drive_req();
    do_txn(1'b0);
    a_m[0] = 16'd77; b_m[0] = 16'd5; a_m[2] = 16'd4000; b_m[2] = 16'd3;
    req_m = 4'b0101; drive_req();
    do_txn(1'b0);
    do_txn(1'b0);

    // Boundary operands.
    a_m[1] = 16'd65535; b_m[1] = 16'd1; a_m[3] = 16'd5; b_m[3] = 16'd9;
    req_m = 4'b1010; drive_req();
    do_txn(1'b0);
    do_txn(1'b0);

    // Stray div_done while idle: no response, no state change.
    bus.div_done = 1'b1; bus.div_q = 16'h1234; bus.div_r = 16'h5678;
    @(negedge clk);
    bus.div_done = 1'b0;
    chk("stray_rsp", bus.rsp_valid, 0);
    chk("stray_busy", bus.busy, 0);
    @(negedge clk);
    chk("stray_q", bus.quotient, last_res[2*WIDTH-1:WIDTH]);
    chk("stray_rsp2", bus.rsp_valid, 0);

    // Reset in the middle of WAIT: the in-flight division is abandoned.
    a_m[1] = 16'd500; b_m[1] = 16'd3; req_m = 4'b0010; drive_req();
    @(negedge clk);
    chk("rst_gnt", bus.gnt, 32'd1 << 1);
    n_gnt_exp++;
    req_m = '0; drive_req();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    ptr_m = 0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rsp_valid != '0) seen = 1'b1;
    end
    chk("midrst_no_rsp", {31'd0, seen}, 0);
    a_m[2] = 16'd81; b_m[2] = 16'd9; req_m = 4'b0100; drive_req();
    do_txn(1'b0);

    // Divide by zero (answered locally only with DIV_ZERO_CHECK_EN).
    a_m[0] = 16'd123; b_m[0] = 16'd0; req_m = 4'b0001; drive_req();
    do_txn(1'b0);

    // Randomized traffic.
    for (int n = 0; n < 80; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_m[i] && $urandom_range(0, 1) == 1) begin
          req_m[i] = 1'b1;
          a_m[i] = rand_op();
          b_m[i] = rand_op();
        end
      end
      if (req_m == '0) begin
        int s;
        s = $urandom_range(0, NREQ - 1);
        req_m[s] = 1'b1;
        a_m[s] = rand_op();
        b_m[s] = rand_op();
      end
      drive_req();
      do_txn($urandom_range(0, 3) == 0);
    end
    req_m = '0; drive_req();

    repeat (3) @(negedge clk);
    chk("gnt_count", n_gnt_seen, n_gnt_exp);
    chk("rsp_count", n_rsp_seen, n_rsp_exp);
    chk("exp_q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/div_share_arbiter.md
# div_share_arbiter

Round-robin scheduler that shares one sequential 16-bit divider core among NREQ requesters. It accepts (dividend, divisor) requests, issues one `div_start` pulse per granted request, and waits for `div_done`. It then returns quotient and remainder to the granted requester with a one-cycle valid pulse. It sits between the application-side clients and the divider core, and owns that core's start/operand inputs exclusively.

## Interface
Parameters:
- `WIDTH`, 16, operand/quotient/remainder width
- `NREQ`, 4, number of requesters (2..8)
- `IDW`, 2, requester index width (must satisfy 2^IDW ≥ NREQ)

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `req`  in  NREQ  per-requester request level
- `a_flat`  in  NREQ*WIDTH  dividends; requester i at bits [i*WIDTH +: WIDTH]
- `b_flat`  in  NREQ*WIDTH  divisors, same packing
- `gnt`  out  NREQ  one-hot, one-cycle pulse: request accepted, operands captured
- `rsp_valid`  out  NREQ  one-hot, one-cycle pulse: result for that requester
- `quotient`  out  WIDTH  result, valid while any `rsp_valid` bit is high
- `remainder`  out  WIDTH  result, valid while any `rsp_valid` bit is high
- `rsp_err`  out  1  divide-by-zero flag, qualified by `rsp_valid` (only with macro)
- `busy`  out  1  high in any state other than IDLE
- `div_start`  out  1  one-cycle start pulse to the divider core
- `div_a`, `div_b`  out  WIDTH  operands to the divider core, held from start until done
- `div_done`  in  1  one-cycle completion pulse from the divider core
- `div_q`, `div_r`  in  WIDTH  divider results, sampled when `div_done` is high

## Operation
- States: IDLE, WAIT, RESP. Reset and IDLE are the same state.
- IDLE, `req`≠0:
  - Select the first set bit searching upward from `ptr`, wrapping at NREQ.
  - At the edge: latch index `id`, set `div_a`/`div_b` from that slot, pulse `gnt[id]` and `div_start`, go to WAIT.
- IDLE, `req`=0: stay in IDLE; all pulses stay low.
- WAIT:
  - `div_start` is low.
  - On `div_done`=1: register `quotient`←`div_q`, `remainder`←`div_r`, set `rsp_valid[id]`, go to RESP.
  - `req` is ignored.
- RESP:
  - Drop `rsp_valid`.
  - Set `ptr` ← (id+1) mod NREQ.
  - Go to IDLE.
- Requester duties:
  - Hold `req` and operands stable until `gnt` is seen.
  - Deassert `req` in the `gnt` cycle unless it wants another operation. A held `req` is re-arbitrated as a new request.
- `div_done` outside WAIT is ignored with no state change.
- Operands pass unchanged; unsigned arithmetic; no width growth.
- Reset (any state, including mid-divide) drives:
  - state→IDLE, `ptr`→0;
  - `gnt`, `rsp_valid`, `div_start`, `busy`, `rsp_err` → 0;
  - `quotient`, `remainder`, `div_a`, `div_b` → 0.
- The divider core shares `rst_n`, so an in-flight division is abandoned and no response is ever sent for it.

## Timing
- `req` sampled in IDLE at cycle T → `gnt` and `div_start` high in cycle T+1.
- `div_done` high in cycle K → `rsp_valid` high in cycle K+1 (RESP) → IDLE at K+2.
- The earliest next grant is therefore in cycle K+3.
- End-to-end latency = divider latency + 3 cycles.
- Exactly one outstanding divider operation at any time.
- `busy` rises in T+1 and falls in K+2.

## Configuration
- `DIV_ZERO_CHECK_EN` defined:
  - In IDLE, a selected request with b=0 still pulses `gnt`, but does not pulse `div_start`.
  - The FSM goes directly to RESP on the next edge with `quotient`=all ones, `remainder`=a, `rsp_err`=1.
- `DIV_ZERO_CHECK_EN` undefined:
  - b=0 is issued to the divider like any other request.
  - `rsp_err` is tied 0.

## Test plan
- Single request: req=4'b0001, a=32200, b=37 → one `gnt[0]`, one `div_start`, `div_a`=32200/`div_b`=37; `rsp_valid[0]` with q=870, r=10, one cycle after `div_done`.
- Round-robin: req=4'b1111 held high, operands 1000/7 on all slots → grant order 0,1,2,3,0; each response q=142, r=6.
- Priority wrap: after serving requester 2, assert req=4'b0101 → requester 0 is skipped in favour of none above 2 except by wrap, so requester 0 is next; then requester 2.
- Boundary operands: a=65535, b=1 → q=65535, r=0; a=5, b=9 → q=0, r=5.
- Reset mid-WAIT: assert `rst_n`=0 for one cycle before `div_done` → all outputs 0, `ptr`=0, no `rsp_valid` afterward; the next request is served normally.
- Divide-by-zero with `DIV_ZERO_CHECK_EN`: a=123, b=0 → `gnt` pulse, no `div_start`, `rsp_valid` one cycle later with q=16'hFFFF, r=123, `rsp_err`=1.
